// File: rtl/input_mapper.sv
// Keyboard/joystick/DIP front end between hps_io and the game core: merges PS/2 keys with
// HPS joystick words per player, adds per-button autofire and coin stretching, captures DIPs.
module input_mapper #(
    parameter int PLAYERS         = 2,
    parameter int BUTTONS         = 3,
    parameter int DIP_BANKS       = 2,
    parameter int AUTOFIRE_PERIOD = 6,
    parameter int COIN_CYCLES     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [10:0]                     ps2_key,
    input  logic [PLAYERS*(6+BUTTONS)-1:0]  joystick,
    input  logic [BUTTONS-1:0]              autofire_en,
    input  logic [24:0]                     ioctl_addr,
    input  logic [7:0]                      ioctl_data,
    input  logic                            ioctl_wr,
    input  logic [7:0]                      ioctl_index,
    output logic [PLAYERS*4-1:0]            joy,
    output logic [PLAYERS*BUTTONS-1:0]      buttons,
    output logic [PLAYERS-1:0]              start,
    output logic [PLAYERS-1:0]              coin,
    output logic [DIP_BANKS*8-1:0]          dip,
    output logic [3:0]                      game_index
);

    localparam int W     = 6 + BUTTONS;
    localparam int AF_W  = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;
    localparam int CNT_W = $clog2(COIN_CYCLES + 1);

    localparam int K_RIGHT = 0, K_LEFT = 1, K_DOWN = 2, K_UP = 3;
    localparam int K_B1 = 4, K_B2 = 5, K_B3 = 6, K_START = 7, K_COIN = 8;

    logic       toggle_q;
    logic [8:0] key_q [2];

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        toggle_q <= ps2_key[10];
        if (reset) begin
            key_q[0] <= '0;
            key_q[1] <= '0;
        end else if (ps2_key[10] != toggle_q) begin
            case (ps2_key[7:0])
                8'h75: key_q[0][K_UP]    <= ps2_key[9];
                8'h72: key_q[0][K_DOWN]  <= ps2_key[9];
                8'h6B: key_q[0][K_LEFT]  <= ps2_key[9];
                8'h74: key_q[0][K_RIGHT] <= ps2_key[9];
                8'h14: key_q[0][K_B1]    <= ps2_key[9];
                8'h11: key_q[0][K_B2]    <= ps2_key[9];
                8'h29: key_q[0][K_B3]    <= ps2_key[9];
                8'h16: key_q[0][K_START] <= ps2_key[9];
                8'h2E: key_q[0][K_COIN]  <= ps2_key[9];
                8'h2D: key_q[1][K_UP]    <= ps2_key[9];
                8'h2B: key_q[1][K_DOWN]  <= ps2_key[9];
                8'h23: key_q[1][K_LEFT]  <= ps2_key[9];
                8'h34: key_q[1][K_RIGHT] <= ps2_key[9];
                8'h1C: key_q[1][K_B1]    <= ps2_key[9];
                8'h1B: key_q[1][K_B2]    <= ps2_key[9];
                8'h15: key_q[1][K_B3]    <= ps2_key[9];
                8'h1E: key_q[1][K_START] <= ps2_key[9];
                8'h36: key_q[1][K_COIN]  <= ps2_key[9];
                default: ;
            endcase
        end
    end

    logic [PLAYERS*4-1:0]       joy_raw;
    logic [PLAYERS*BUTTONS-1:0] btn_raw;
    logic [PLAYERS-1:0]         start_raw;
    logic [PLAYERS-1:0]         coin_raw;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [8:0]   kb;
        logic [W-1:0] js;
        assign js = joystick[p*W +: W];
        if (p < 2) begin : g_kb
            assign kb = key_q[p];
        end else begin : g_no_kb
            assign kb = '0;
        end
        assign joy_raw[p*4 +: 4] = {js[3] | kb[K_UP], js[2] | kb[K_DOWN],
                                    js[0] | kb[K_RIGHT], js[1] | kb[K_LEFT]};
        for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
            if (b < 3) begin : g_kb_btn
                assign btn_raw[p*BUTTONS + b] = js[4+b] | kb[K_B1+b];
            end else begin : g_js_btn
                assign btn_raw[p*BUTTONS + b] = js[4+b];
            end
        end
        assign start_raw[p] = js[4+BUTTONS] | kb[K_START];
        assign coin_raw[p]  = js[5+BUTTONS] | kb[K_COIN];
    end

    logic [AF_W-1:0] af_cnt;
    logic            af_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (af_cnt == AF_W'(AUTOFIRE_PERIOD - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 1'b1;
        end
    end

    logic [CNT_W-1:0]   coin_cnt [PLAYERS];
    logic [PLAYERS-1:0] coin_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            joy       <= '0;
            buttons   <= '0;
            start     <= '0;
            coin      <= '0;
            coin_prev <= '0;
            for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= '0;
        end else begin
            joy       <= joy_raw;
            start     <= start_raw;
            coin_prev <= coin_raw;
            for (int p = 0; p < PLAYERS; p++) begin
                for (int b = 0; b < BUTTONS; b++)
                    buttons[p*BUTTONS + b] <= btn_raw[p*BUTTONS + b] & (~autofire_en[b] | af_phase);
                // A fresh rising edge always restarts the stretch window, even mid-count.
                if (coin_raw[p] && !coin_prev[p])
                    coin_cnt[p] <= CNT_W'(COIN_CYCLES);
                else if (coin_cnt[p] != '0)
                    coin_cnt[p] <= coin_cnt[p] - 1'b1;
                coin[p] <= coin_raw[p] | (coin_cnt[p] != '0);
            end
        end
    end

    // NOTE: configuration state is deliberately outside reset; it only takes its power-up value.
    logic [7:0] dip_q [DIP_BANKS] = '{default: '0};
    logic [3:0] game_index_q      = '0;

    always_ff @(posedge clk) begin
        if (ioctl_wr && ioctl_index == 8'd254) begin
            for (int i = 0; i < DIP_BANKS; i++)
                if (ioctl_addr == 25'(i)) dip_q[i] <= ioctl_data;
        end
        if (ioctl_wr && ioctl_index == 8'd1)
            game_index_q <= ioctl_data[3:0];
    end

    for (genvar i = 0; i < DIP_BANKS; i++) begin : g_dip
        assign dip[i*8 +: 8] = dip_q[i];
    end
    assign game_index = game_index_q;

endmodule

// File: tb/tb_input_mapper.sv
// Directed bench for input_mapper: a default 2x3 instance plus a 4-player, 5-button instance
// sharing clock, reset, PS/2 and ioctl stimulus.
module tb_input_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [10:0] ps2_key;
    logic [17:0] joystick;
    logic [2:0]  autofire_en;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [7:0]  joy;
    logic [5:0]  buttons;
    logic [1:0]  start;
    logic [1:0]  coin;
    logic [15:0] dip;
    logic [3:0]  game_index;

    logic [43:0] joystick4;
    logic [4:0]  autofire_en4;
    logic [15:0] joy4;
    logic [19:0] buttons4;
    logic [3:0]  start4;
    logic [3:0]  coin4;
    logic [15:0] dip4;
    logic [3:0]  game_index4;

    input_mapper dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
        .autofire_en(autofire_en), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .joy(joy), .buttons(buttons),
        .start(start), .coin(coin), .dip(dip), .game_index(game_index)
    );

    input_mapper #(.PLAYERS(4), .BUTTONS(5)) dut4 (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick4),
        .autofire_en(autofire_en4), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .joy(joy4), .buttons(buttons4),
        .start(start4), .coin(coin4), .dip(dip4), .game_index(game_index4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_data  = data;
        ioctl_wr    = 1'b1;
        step();
        ioctl_wr    = 1'b0;
    endtask

    typedef struct {
        logic [17:0] js;
        logic [7:0]  exp_joy;
        logic [5:0]  exp_btn;
        logic [1:0]  exp_start;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{18'h00001, 8'h02, 6'h00, 2'b00};  // P1 right
        vecs[1] = '{18'h00002, 8'h01, 6'h00, 2'b00};  // P1 left
        vecs[2] = '{18'h0000C, 8'h0C, 6'h00, 2'b00};  // P1 down+up
        vecs[3] = '{18'h00050, 8'h00, 6'h05, 2'b00};  // P1 b1+b3
        vecs[4] = '{18'h00080, 8'h00, 6'h00, 2'b01};  // P1 start
        vecs[5] = '{18'h00200, 8'h20, 6'h00, 2'b00};  // P2 right
        vecs[6] = '{18'h05000, 8'h80, 6'h10, 2'b00};  // P2 up+b2
        vecs[7] = '{18'h10000, 8'h00, 6'h00, 2'b10};  // P2 start
        vecs[8] = '{18'h1FEFF, 8'hFF, 6'h3F, 2'b11};  // everything except coins
        vecs[9] = '{18'h00000, 8'h00, 6'h00, 2'b00};

        reset        = 1'b1;
        ps2_key      = '0;
        joystick     = '0;
        autofire_en  = '0;
        joystick4    = '0;
        autofire_en4 = '0;
        ioctl_addr   = '0;
        ioctl_data   = '0;
        ioctl_wr     = 1'b0;
        ioctl_index  = '0;
        step();
        check("init dip", dip, 16'h0000);
        check("init game_index", game_index, 4'h0);
        check("reset joy", joy, 8'h00);
        check("reset buttons", buttons, 6'h00);
        step();
        reset = 1'b0;
        step();

        // Key path: two cycles from toggle to output.
        send_key(8'h75, 1'b1);
        step();
        check("key up lat1", joy, 8'h00);
        step();
        check("key up lat2", joy, 8'h08);
        send_key(8'h75, 1'b0);
        step();
        check("key up rel lat1", joy, 8'h08);
        step();
        check("key up rel lat2", joy, 8'h00);
        send_key(8'h99, 1'b1);
        step();
        step();
        check("unknown key joy", joy, 8'h00);
        check("unknown key buttons", buttons, 6'h00);
        check("unknown key start", start, 2'b00);

        // Joystick merge table, one-cycle latency.
        for (int i = 0; i < 10; i++) begin
            joystick = vecs[i].js;
            step();
            check($sformatf("vec%0d joy", i), joy, vecs[i].exp_joy);
            check($sformatf("vec%0d buttons", i), buttons, vecs[i].exp_btn);
            check($sformatf("vec%0d start", i), start, vecs[i].exp_start);
            check($sformatf("vec%0d coin", i), coin, 2'b00);
        end

        // Toggle flipped while reset is asserted must not create a key event.
        reset   = 1'b1;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h75};
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("reset toggle joy", joy, 8'h00);
        check("reset toggle buttons", buttons, 6'h00);
        check("reset toggle start", start, 2'b00);
        check("reset toggle coin", coin, 2'b00);

        // Autofire on button 1 only, both held.
        joystick    = 18'h00030;
        autofire_en = 3'b001;
        reset       = 1'b1;
        step();
        reset = 1'b0;
        check("af reset buttons", buttons, 6'h00);
        for (int k = 1; k <= 18; k++) begin
            step();
            check($sformatf("af b1 k%0d", k), buttons[0], (((k - 1) / 6) % 2) == 0);
            check($sformatf("af b2 k%0d", k), buttons[1], 1'b1);
        end
        joystick    = '0;
        autofire_en = '0;
        for (int i = 0; i < 3; i++) step();

        // Single P2 coin pulse: high for exactly 17 cycles.
        joystick = 18'h20000;
        step();
        joystick = '0;
        check("coin1 k1", coin, 2'b10);
        for (int k = 2; k <= 19; k++) begin
            step();
            check($sformatf("coin1 k%0d", k), coin, (k <= 17) ? 2'b10 : 2'b00);
        end

        // Retrigger at cycle 10 stretches to 16 cycles after it.
        joystick = 18'h20000;
        step();
        joystick = '0;
        check("coin2 k1", coin, 2'b10);
        for (int k = 2; k <= 28; k++) begin
            if (k == 10) joystick = 18'h20000;
            step();
            if (k == 10) joystick = '0;
            check($sformatf("coin2 k%0d", k), coin, (k <= 26) ? 2'b10 : 2'b00);
        end

        // DIP and game index capture.
        ioctl_write(8'd254, 25'd0, 8'hA5);
        ioctl_write(8'd254, 25'd1, 8'h3C);
        ioctl_write(8'd254, 25'd5, 8'hFF);
        ioctl_write(8'd254, 25'd2, 8'h77);
        step();
        check("dip write", dip, 16'h3CA5);
        check("dip4 write", dip4, 16'h3CA5);
        reset = 1'b1;
        step();
        step();
        check("dip after reset", dip, 16'h3CA5);
        ioctl_write(8'd254, 25'd0, 8'h5A);
        reset = 1'b0;
        step();
        check("dip write in reset", dip, 16'h3C5A);
        ioctl_write(8'd2, 25'd0, 8'h0F);
        ioctl_write(8'd1, 25'd0, 8'h13);
        step();
        check("game_index", game_index, 4'h3);
        check("dip other index", dip, 16'h3C5A);

        // 4-player, 5-button instance.
        joystick4 = 44'd1 << 41;
        check("p4 b5 before edge", buttons4, 20'h00000);
        step();
        check("p4 b5", buttons4, 20'h80000);
        joystick4 = '0;
        step();
        check("p4 b5 release", buttons4, 20'h00000);
        send_key(8'h15, 1'b1);
        step();
        step();
        check("p2 b3 key wide", buttons4, 20'h00080);
        check("p2 b3 key narrow", buttons, 6'h20);
        send_key(8'h15, 1'b0);
        step();
        step();
        check("p2 b3 key rel wide", buttons4, 20'h00000);
        send_key(8'h34, 1'b1);
        step();
        step();
        check("p2 right key wide", joy4, 16'h0020);
        check("p2 right key start", start4, 4'b0000);
        send_key(8'h34, 1'b0);
        step();
        step();
        check("p2 right rel wide", joy4, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
